wb_stage: RTL and testbench



---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/wb_stage.sv | 113 +++++++++++
 tb/tb_wb_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage slice (wb_stage, wb_fifo).
package wb_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 20;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_ALU,
      SEL_FIFO
   } wb_sel_e;

   function automatic logic rd_writable(input logic [ADDR_W-1:0] rd,
                                        input int unsigned      num_regs);
      return (rd != '0) && (32'(rd) < num_regs);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for long-latency results waiting for an idle write slot.
// With WB_SCOREBOARD_EN, exposes per-slot occupancy and destination for hazard checks.
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  wb_entry_t                    push_entry,
   input  logic                         pop,
   output logic [CNT_W-1:0]             count,
   output logic                         full,
   output logic                         empty,
   output wb_entry_t                    head
`ifdef WB_SCOREBOARD_EN
   ,
   output logic [DEPTH-1:0]             slot_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0] slot_rd
`endif
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

`ifdef WB_SCOREBOARD_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_valid <= '0;
      end else begin
         // Pop clears before push sets, so a slot reused in the same cycle stays valid.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (do_pop && (rd_ptr == PTR_W'(i)))  slot_valid[i] <= 1'b0;
            if (do_push && (wr_ptr == PTR_W'(i))) slot_valid[i] <= 1'b1;
         end
      end
   end

   always_comb begin
      slot_rd = '0;
      for (int unsigned i = 0; i < DEPTH; i++) slot_rd[i] = mem[i].rd;
   end
`endif

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges ALU results and buffered long-port results onto the single bank write port.
// Optional hazard-check ports are built when WB_SCOREBOARD_EN is defined.
module wb_stage
   import wb_pkg::*;
#(
   parameter int unsigned NUM_REGS   = wb_pkg::NUM_REGS,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             alu_valid,
   input  logic [ADDR_W-1:0]                alu_rd,
   input  logic [DATA_W-1:0]                alu_data,
   input  logic                             lng_valid,
   output logic                             lng_ready,
   input  logic [ADDR_W-1:0]                lng_rd,
   input  logic [DATA_W-1:0]                lng_data,
   output logic                             pw,
   output logic [ADDR_W-1:0]                write_addr,
   output logic [DATA_W-1:0]                write_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
`ifdef WB_SCOREBOARD_EN
   ,
   input  logic [ADDR_W-1:0]                chk_addr1,
   input  logic [ADDR_W-1:0]                chk_addr2,
   output logic                             chk_hazard1,
   output logic                             chk_hazard2
`endif
);

   logic      alu_ok;
   logic      lng_push;
   logic      fifo_pop;
   logic      fifo_full;
   logic      fifo_empty;
   logic      ready_en;
   wb_entry_t fifo_head;
   wb_sel_e   sel;

`ifdef WB_SCOREBOARD_EN
   logic [FIFO_DEPTH-1:0]             slot_valid;
   logic [FIFO_DEPTH-1:0][ADDR_W-1:0] slot_rd;
`endif

   assign alu_ok    = alu_valid && rd_writable(alu_rd, NUM_REGS);
   // Invalid long writes still handshake; they just never enter the buffer.
   assign lng_push  = lng_valid && lng_ready && rd_writable(lng_rd, NUM_REGS);
   assign lng_ready = ready_en && !fifo_full;
   assign fifo_pop  = (sel == SEL_FIFO);

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (lng_push),
      .push_entry ('{rd: lng_rd, data: lng_data}),
      .pop        (fifo_pop),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (fifo_head)
`ifdef WB_SCOREBOARD_EN
      ,
      .slot_valid (slot_valid),
      .slot_rd    (slot_rd)
`endif
   );

   always_comb begin
      sel = SEL_NONE;
      if (alu_ok)           sel = SEL_ALU;
      else if (!fifo_empty) sel = SEL_FIFO;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pw         <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         ready_en   <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         case (sel)
            SEL_ALU: begin
               pw         <= 1'b1;
               write_addr <= alu_rd;
               write_data <= alu_data;
            end
            SEL_FIFO: begin
               pw         <= 1'b1;
               write_addr <= fifo_head.rd;
               write_data <= fifo_head.data;
            end
            default: pw <= 1'b0;
         endcase
      end
   end

`ifdef WB_SCOREBOARD_EN
   always_comb begin
      chk_hazard1 = pw && (write_addr == chk_addr1);
      chk_hazard2 = pw && (write_addr == chk_addr2);
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (slot_valid[i] && (slot_rd[i] == chk_addr1)) chk_hazard1 = 1'b1;
         if (slot_valid[i] && (slot_rd[i] == chk_addr2)) chk_hazard2 = 1'b1;
      end
      if (chk_addr1 == '0) chk_hazard1 = 1'b0;
      if (chk_addr2 == '0) chk_hazard2 = 1'b0;
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage; scoreboard-port checks are included when WB_SCOREBOARD_EN is defined.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lng_valid;
   logic        lng_ready;
   logic [4:0]  lng_rd;
   logic [31:0] lng_data;
   logic        pw;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [1:0]  fifo_count;
`ifdef WB_SCOREBOARD_EN
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        chk_hazard1;
   logic        chk_hazard2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_stage #(
      .NUM_REGS   (20),
      .FIFO_DEPTH (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .lng_valid  (lng_valid),
      .lng_ready  (lng_ready),
      .lng_rd     (lng_rd),
      .lng_data   (lng_data),
      .pw         (pw),
      .write_addr (write_addr),
      .write_data (write_data),
      .fifo_count (fifo_count)
`ifdef WB_SCOREBOARD_EN
      ,
      .chk_addr1   (chk_addr1),
      .chk_addr2   (chk_addr2),
      .chk_hazard1 (chk_hazard1),
      .chk_hazard2 (chk_hazard2)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v; alu_rd = rd; alu_data = d;
   endtask

   task automatic set_lng(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lng_valid = v; lng_rd = rd; lng_data = d;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_alu(1'b0, 5'd0, 32'h0);
      set_lng(1'b1, 5'd3, 32'h55);
      step(); step();
      checks++; if (lng_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b want 0", lng_ready); end
      checks++; if (pw !== 1'b0) begin errors++; $display("FAIL rst_pw got %0b want 0", pw); end
      checks++; if (write_addr !== 5'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", write_addr); end
      checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", write_data); end
      checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
      reset = 1'b0;
      set_lng(1'b0, 5'd0, 32'h0);
      #1;
      checks++; if (lng_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_predge got %0b want 0", lng_ready); end
      step();
      checks++; if (lng_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_edge got %0b want 1", lng_ready); end
      checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rst_count_edge got %0d want 0", fifo_count); end
   endtask

   task automatic test_alu();
      set_alu(1'b1, 5'd5, 32'hDEADBEEF);
      step();
      set_alu(1'b0, 5'd0, 32'h0);
      checks++; if (pw !== 1'b1) begin errors++; $display("FAIL alu_pw got %0b want 1", pw); end
      checks++; if (write_addr !== 5'd5) begin errors++; $display("FAIL alu_addr got %0d want 5", write_addr); end
      checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data got %h want deadbeef", write_data); end
      step();
      checks++; if (pw !== 1'b0) begin errors++; $display("FAIL alu_pw_after got %0b want 0", pw); end
      checks++; if (write_addr !== 5'd5 || write_data !== 32'hDEADBEEF)
         begin errors++; $display("FAIL alu_hold got %0d/%h want 5/deadbeef", write_addr, write_data); end
   endtask

   task automatic test_long();
      set_lng(1'b1, 5'd3, 32'h11);
      step();
      set_lng(1'b0, 5'd0, 32'h0);
      checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL lng_count1 got %0d want 1", fifo_count); end
      checks++; if (pw !== 1'b0) begin errors++; $display("FAIL lng_nobypass got %0b want 0", pw); end
      step();
      checks++; if (pw !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'h11)
         begin errors++; $display("FAIL lng_write got %0b/%0d/%h want 1/3/11", pw, write_addr, write_data); end
      checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL lng_count0 got %0d want 0", fifo_count); end
      step();
      checks++; if (pw !== 1'b0) begin errors++; $display("FAIL lng_pw_after got %0b want 0", pw); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_addr [6];
      logic [1:0] exp_cnt  [6];
      logic       exp_rdy  [6];
      exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8};
      exp_cnt  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
      exp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         if (i < 4) set_alu(1'b1, 5'(i + 1), 32'h100 + 32'(i));
         else       set_alu(1'b0, 5'd0, 32'h0);
         if (i == 0)      set_lng(1'b1, 5'd7, 32'h77);
         else if (i == 1) set_lng(1'b1, 5'd8, 32'h88);
         else             set_lng(1'b0, 5'd0, 32'h0);
         step();
         checks++; if (pw !== 1'b1 || write_addr !== exp_addr[i])
            begin errors++; $display("FAIL b2b_addr[%0d] got %0b/%0d want 1/%0d", i, pw, write_addr, exp_addr[i]); end
         checks++; if (fifo_count !== exp_cnt[i])
            begin errors++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, fifo_count, exp_cnt[i]); end
         checks++; if (lng_ready !== exp_rdy[i])
            begin errors++; $display("FAIL b2b_ready[%0d] got %0b want %0b", i, lng_ready, exp_rdy[i]); end
      end
      checks++; if (write_data !== 32'h88) begin errors++; $display("FAIL b2b_data got %h want 88", write_data); end
      step();
      checks++; if (pw !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", pw); end
   endtask

   task automatic test_invalid();
      logic [4:0] bad [2];
      bad = '{5'd0, 5'd25};
      for (int i = 0; i < 2; i++) begin
         set_alu(1'b1, bad[i], 32'hBAD0);
         set_lng(1'b1, bad[i], 32'hBAD1);
         #1;
         checks++; if (lng_ready !== 1'b1) begin errors++; $display("FAIL inv_ready[%0d] got %0b want 1", i, lng_ready); end
         step();
         checks++; if (pw !== 1'b0) begin errors++; $display("FAIL inv_pw[%0d] got %0b want 0", i, pw); end
         checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL inv_count[%0d] got %0d want 0", i, fifo_count); end
      end
      set_lng(1'b0, 5'd0, 32'h0);
      set_alu(1'b1, 5'd20, 32'h20);
      step();
      checks++; if (pw !== 1'b0) begin errors++; $display("FAIL inv_rd20 got %0b want 0", pw); end
      set_alu(1'b1, 5'd19, 32'h19);
      step();
      checks++; if (pw !== 1'b1 || write_addr !== 5'd19)
         begin errors++; $display("FAIL inv_rd19 got %0b/%0d want 1/19", pw, write_addr); end
      // An invalid ALU write leaves the slot free for a buffered result.
      set_alu(1'b1, 5'd2, 32'h2);
      set_lng(1'b1, 5'd10, 32'hA);
      step();
      set_lng(1'b0, 5'd0, 32'h0);
      set_alu(1'b1, 5'd25, 32'h25);
      step();
      set_alu(1'b0, 5'd0, 32'h0);
      checks++; if (pw !== 1'b1 || write_addr !== 5'd10 || write_data !== 32'hA)
         begin errors++; $display("FAIL inv_alu_idle_pop got %0b/%0d/%h want 1/10/a", pw, write_addr, write_data); end
      step();
   endtask

`ifdef WB_SCOREBOARD_EN
   task automatic test_scoreboard();
      chk_addr1 = 5'd9;
      chk_addr2 = 5'd4;
      set_alu(1'b1, 5'd1, 32'h1);
      set_lng(1'b1, 5'd9, 32'h99);
      step();
      set_lng(1'b0, 5'd0, 32'h0);
      checks++; if (chk_hazard1 !== 1'b1) begin errors++; $display("FAIL sb_fifo_hz got %0b want 1", chk_hazard1); end
      checks++; if (chk_hazard2 !== 1'b0) begin errors++; $display("FAIL sb_other_hz got %0b want 0", chk_hazard2); end
      chk_addr2 = 5'd1;
      #1;
      checks++; if (chk_hazard2 !== 1'b1) begin errors++; $display("FAIL sb_outreg_hz got %0b want 1", chk_hazard2); end
      set_alu(1'b0, 5'd0, 32'h0);
      step();
      checks++; if (pw !== 1'b1 || write_addr !== 5'd9 || chk_hazard1 !== 1'b1)
         begin errors++; $display("FAIL sb_drain got %0b/%0d/%0b want 1/9/1", pw, write_addr, chk_hazard1); end
      step();
      checks++; if (chk_hazard1 !== 1'b0) begin errors++; $display("FAIL sb_cleared got %0b want 0", chk_hazard1); end
      chk_addr1 = 5'd0;
      #1;
      checks++; if (chk_hazard1 !== 1'b0) begin errors++; $display("FAIL sb_addr0 got %0b want 0", chk_hazard1); end
      // Two buffered entries so the FIFO is still occupied while the first drains.
      chk_addr1 = 5'd9;
      set_alu(1'b1, 5'd1, 32'h1);
      set_lng(1'b1, 5'd9, 32'h91);
      step();
      set_lng(1'b1, 5'd9, 32'h92);
      step();
      set_lng(1'b0, 5'd0, 32'h0);
      set_alu(1'b0, 5'd0, 32'h0);
      step();
      checks++; if (pw !== 1'b1 || fifo_count !== 2'd1)
         begin errors++; $display("FAIL sb_middrain got %0b/%0d want 1/1", pw, fifo_count); end
      reset = 1'b1;
      #1;
      checks++; if (pw !== 1'b0 || chk_hazard1 !== 1'b0 || fifo_count !== 2'd0)
         begin errors++; $display("FAIL sb_reset got %0b/%0b/%0d want 0/0/0", pw, chk_hazard1, fifo_count); end
      step();
      reset = 1'b0;
      step();
   endtask
`endif

   initial begin
`ifdef WB_SCOREBOARD_EN
      chk_addr1 = 5'd0;
      chk_addr2 = 5'd0;
`endif
      test_reset();
      test_alu();
      test_long();
      test_back_to_back();
      test_invalid();
`ifdef WB_SCOREBOARD_EN
      test_scoreboard();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
